// File: rtl/pc_unit_if.sv
// pc_unit_if: control and address bundle between the hazard unit / EX stage
// and the program-counter unit. The master drives control, the slave (pc_unit) returns PC state.
interface pc_unit_if #(
    parameter int XLEN = 32
);
    logic            stall_i;
    logic            redirect_i;
    logic [XLEN-1:0] target_i;
    logic            call_i;
    logic            ret_i;
    logic            trap_i;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] pc_plus4_o;
    logic [XLEN-1:0] epc_o;
    logic            misalign_o;
    logic            ras_empty_o;

    modport master (
        output stall_i, redirect_i, target_i, call_i, ret_i, trap_i,
        input  pc_o, pc_plus4_o, epc_o, misalign_o, ras_empty_o
    );

    modport slave (
        input  stall_i, redirect_i, target_i, call_i, ret_i, trap_i,
        output pc_o, pc_plus4_o, epc_o, misalign_o, ras_empty_o
    );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with redirect, trap, stall, EPC and a
// circular return-address stack. Ports: clk, reset (sync, active-high), bus (pc_unit_if.slave).
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int              RAS_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       reset,
    pc_unit_if.slave   bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] epc;
    logic            misalign;
    logic [XLEN-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]   ras_ptr;
    logic [CW-1:0]   ras_cnt;
    logic [XLEN-1:0] pc_plus4;
    logic            bad_target;
    logic            push;
    logic            pop;

    assign pc_plus4   = pc + XLEN'(4);
    assign bad_target = bus.target_i[1:0] != 2'b00;

    // Priority: trap > misaligned redirect > redirect > stall > ret > seq.
    assign push = ~bus.trap_i & bus.redirect_i & ~bad_target & bus.call_i;
    assign pop  = ~bus.trap_i & ~bus.redirect_i & ~bus.stall_i
                & bus.ret_i & (ras_cnt != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_VECTOR;
            epc      <= '0;
            misalign <= 1'b0;
            ras_ptr  <= '0;
            ras_cnt  <= '0;
        end else begin
            misalign <= 1'b0;
            if (bus.trap_i) begin
                pc  <= TRAP_VECTOR;
                epc <= pc;
            end else if (bus.redirect_i && bad_target) begin
                pc       <= TRAP_VECTOR;
                epc      <= bus.target_i;
                misalign <= 1'b1;
            end else if (bus.redirect_i) begin
                pc <= bus.target_i;
            end else if (bus.stall_i) begin
                pc <= pc;
            end else if (pop) begin
                pc <= ras_mem[ras_ptr - PW'(1)];
            end else begin
                pc <= pc_plus4;
            end

            if (push) begin
                ras_ptr <= ras_ptr + PW'(1);
                // Full stack overwrites its oldest entry; count stays saturated.
                if (ras_cnt != CW'(RAS_DEPTH))
                    ras_cnt <= ras_cnt + CW'(1);
            end else if (pop) begin
                ras_ptr <= ras_ptr - PW'(1);
                ras_cnt <= ras_cnt - CW'(1);
            end
        end
    end

    // Entries need no reset: they are only read while the count is non-zero.
    always_ff @(posedge clk) begin
        if (!reset && push)
            ras_mem[ras_ptr] <= pc_plus4;
    end

    assign bus.pc_o        = pc;
    assign bus.pc_plus4_o  = pc_plus4;
    assign bus.epc_o       = epc;
    assign bus.misalign_o  = misalign;
    assign bus.ras_empty_o = ras_cnt == '0;
endmodule
